conv_scan_ctrl: RTL and testbench
=================================

# conv_scan_ctrl

Raster-scan controller for the conv datapath. It accepts one input pixel per handshake, tracks the row/column position of every accepted pixel, and produces `out_vld_rc`, the position-valid qualifier that the conv output-valid stage ANDs with the 3x3 window valid. It also sequences a frame (start, run, flush, done) and counts produced outputs, so the conv engine is told where each window lands for any configured size and stride.

## Interface
Parameters:
- `K`, 3: kernel size. Windows are KxK.
- `CW`, 8: width of the row, column and size counters. The maximum image dimension is 2^CW-1.
- `FLUSH_CYC`, 2: number of cycles waited after the last pixel so that downstream registered stages drain before `done`.

Ports (reset is `rst_n`, asynchronous, active-low; clock is `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: frame start pulse. Sampled only in IDLE.
- `cfg_w` in CW: image width, latched on an accepted `start`.
- `cfg_h` in CW: image height, latched on an accepted `start`.
- `cfg_stride` in 2: window stride, legal range 1..3. Latched on an accepted `start`.
- `pix_vld` in 1: upstream pixel valid.
- `pix_rdy` out 1: ready to accept a pixel.
- `row` out CW: row of the last accepted pixel (registered).
- `col` out CW: column of the last accepted pixel (registered).
- `out_vld_rc` out 1: the last accepted pixel completes a valid strided window.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: one-cycle end-of-frame pulse.
- `err` out 1: illegal configuration flag, valid while `done` is high.
- `out_cnt` out 2*CW: number of `out_vld_rc` pulses in the current frame.

## Operation
The block has four states: IDLE, RUN, FLUSH, DONE.

- **IDLE**
  - `pix_rdy`=0.
  - When `start`=1, latch the configuration.
  - If the configuration is legal, clear the counters and go to RUN.
  - The configuration is illegal if `cfg_w`<K, `cfg_h`<K or `cfg_stride`=0. In that case go to DONE with `err`=1.
- **RUN**
  - `pix_rdy`=1. A pixel is accepted when `pix_vld`&`pix_rdy`.
  - Column and row advance on each accepted pixel:
    - The column counter increments on each accept.
    - At `cfg_w`-1 the column wraps to 0 and the row increments.
    - On the accept at (`cfg_h`-1, `cfg_w`-1), go to FLUSH.
  - Stride phase counters: `rph` and `cph` start at 0 when the row or column reaches K-1. Each increments modulo `cfg_stride` and resets at every row or column wrap.
  - `out_vld_rc` is registered on the accept cycle as: row≥K-1 AND col≥K-1 AND rph==0 AND cph==0. It is 0 on cycles with no accept.
  - `out_cnt` increments together with each `out_vld_rc`.
- **FLUSH**
  - `pix_rdy`=0.
  - Count FLUSH_CYC cycles, then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `err` holds until the next accepted `start`.
  - `out_cnt` holds until the next accepted `start`.

Rules:
- `start` is ignored outside IDLE.
- The configuration is frozen during a frame.
- A `pix_vld` stall leaves every counter and phase unchanged.
- Reset mid-frame returns to IDLE immediately and discards the frame.
- Reset values:
  - State is IDLE.
  - `pix_rdy`, `out_vld_rc`, `busy`, `done` and `err` are 0.
  - `row`, `col` and `out_cnt` are 0.

## Timing
- `out_vld_rc`, `row` and `col` appear one cycle after the accepting edge. This is the same cycle in which the window generator asserts its window valid.
- The conv output-valid stage then adds one more register.
- `pix_rdy` rises the cycle after `start` is accepted. It falls the cycle after the last accept.
- `done` asserts FLUSH_CYC+1 cycles after the last accept.
- For an illegal configuration, `done` asserts 1 cycle after `start`.
- Expected output count: `out_cnt` = ((`cfg_h`-K)/s+1)·((`cfg_w`-K)/s+1), using integer division, where s = `cfg_stride`.
- Full throughput: one accept per cycle with no bubbles.

## Structure
- Package `conv_pkg` holds:
  - the state enum: IDLE, RUN, FLUSH, DONE;
  - the K and CW defaults;
  - the stride-legality constant.
- One sub-module, `scan_axis_cnt`, is instantiated twice:
  - column instance: counts `inc`, wraps at `lim`, outputs position and stride phase.
  - row instance: same function, advanced by the column instance's wrap.

## Test plan
1. 5x5 image, stride 1, continuous `pix_vld` → 9 `out_vld_rc` pulses, the first at (2,2). `out_cnt`=9. `done` 3 cycles after the last accept.
2. 6x6 image, stride 2 → pulses only at (2,2), (2,4), (4,2), (4,4). `out_cnt`=4.
3. 5x5 image, stride 1, `pix_vld` toggling 1/0 → same 9 pulses at the same positions. No pulse on stall cycles.
4. `cfg_w`=2 → `done`=1 and `err`=1 one cycle after `start`. `pix_rdy` never rises.
5. Reset asserted after 10 accepts → all outputs 0 immediately. A following 3x3 frame yields exactly 1 pulse at (2,2).
6. `start` pulsed during RUN → ignored. The configuration and counters are unaffected and the frame completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv raster-scan controller.
// Holds the frame FSM state encoding and configuration limits.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } scan_state_e;

    localparam int K_DEF  = 3;
    localparam int CW_DEF = 8;

    // Smallest legal window stride; zero would never advance a window.
    localparam logic [1:0] STRIDE_MIN = 2'd1;

endpackage

// File: rtl/scan_axis_cnt.sv
// One scan axis: position counter with wrap plus stride phase.
// The position is the index of the next pixel to be accepted.
module scan_axis_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] lim,
    input  logic [CW-1:0] kth,
    input  logic [1:0]    stride,
    output logic [CW-1:0] pos,
    output logic [1:0]    ph,
    output logic          wrap
);

    logic [CW-1:0] pos_q, pos_d;
    logic [1:0]    ph_q, ph_d;
    logic          at_lim;

    assign at_lim = (pos_q == lim);
    assign wrap   = inc & at_lim;
    assign pos    = pos_q;
    assign ph     = ph_q;

    // Advance position; phase runs modulo stride once past kth.
    always_comb begin
        pos_d = pos_q;
        ph_d  = ph_q;
        if (clr) begin
            pos_d = '0;
            ph_d  = '0;
        end else if (inc) begin
            if (at_lim) begin
                pos_d = '0;
                ph_d  = '0;
            end else begin
                pos_d = pos_q + 1'b1;
                if (pos_q >= kth) begin
                    if (ph_q == stride - 2'd1) begin
                        ph_d = '0;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
        end
    end

    // Axis state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            ph_q  <= '0;
        end else begin
            pos_q <= pos_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Raster-scan controller: tracks pixel row/col, flags strided
// window positions, sequences a frame and counts outputs.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int CW        = CW_DEF,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   cfg_w,
    input  logic [CW-1:0]   cfg_h,
    input  logic [1:0]      cfg_stride,
    input  logic            pix_vld,
    output logic            pix_rdy,
    output logic [CW-1:0]   row,
    output logic [CW-1:0]   col,
    output logic            out_vld_rc,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2*CW-1:0] out_cnt
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_RUN   = S_RUN;
    localparam logic [1:0] ST_FLUSH = S_FLUSH;
    localparam logic [1:0] ST_DONE  = S_DONE;

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] K_CW  = CW'(K);
    localparam logic [CW-1:0] KM1   = CW'(K - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   w_q, w_d;
    logic [CW-1:0]   h_q, h_d;
    logic [1:0]      s_q, s_d;
    logic            err_q, err_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            vld_q, vld_d;
    logic [2*CW-1:0] cnt_q, cnt_d;

    logic          start_acc;
    logic          cfg_ok;
    logic          accept;
    logic          last_pix;
    logic [CW-1:0] col_pos, row_pos;
    logic [1:0]    col_ph, row_ph;
    logic          col_wrap, row_wrap;

    assign pix_rdy    = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) | (state_q == ST_FLUSH);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign row        = row_q;
    assign col        = col_q;
    assign out_vld_rc = vld_q;
    assign out_cnt    = cnt_q;

    assign start_acc = start & (state_q == ST_IDLE);
    assign cfg_ok    = (cfg_w >= K_CW) & (cfg_h >= K_CW)
                     & (cfg_stride >= STRIDE_MIN);
    assign accept    = pix_vld & pix_rdy;
    assign last_pix  = accept & col_wrap & row_wrap;

    scan_axis_cnt #(.CW(CW)) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc),
        .inc    (accept),
        .lim    (w_q - 1'b1),
        .kth    (KM1),
        .stride (s_q),
        .pos    (col_pos),
        .ph     (col_ph),
        .wrap   (col_wrap)
    );

    scan_axis_cnt #(.CW(CW)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc),
        .inc    (accept & col_wrap),
        .lim    (h_q - 1'b1),
        .kth    (KM1),
        .stride (s_q),
        .pos    (row_pos),
        .ph     (row_ph),
        .wrap   (row_wrap)
    );

    // Frame sequencing and configuration capture.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        s_d     = s_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d     = cfg_w;
                    h_d     = cfg_h;
                    s_d     = cfg_stride;
                    err_d   = ~cfg_ok;
                    state_d = cfg_ok ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_pix) begin
                    fcnt_d  = '0;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Position outputs, window-valid qualifier and output count.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        vld_d = 1'b0;
        cnt_d = cnt_q;
        if (start_acc) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            row_d = row_pos;
            col_d = col_pos;
            vld_d = (row_pos >= KM1) & (col_pos >= KM1)
                  & (row_ph == 2'd0) & (col_ph == 2'd0);
            if (vld_d) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            s_q     <= s_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench for conv_scan_ctrl: expected window positions
// are queued by the stimulus and popped by a pulse monitor.
module tb_conv_scan_ctrl;

    localparam int K  = 3;
    localparam int CW = 8;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_w = '0;
    logic [CW-1:0] cfg_h = '0;
    logic [1:0]    cfg_stride = '0;
    logic          pix_vld = 1'b0;
    logic          pix_rdy;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          out_vld_rc;
    logic          busy;
    logic          done;
    logic          err;
    logic [2*CW-1:0] out_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    conv_scan_ctrl #(.K(K), .CW(CW), .FLUSH_CYC(FC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .cfg_stride (cfg_stride),
        .pix_vld    (pix_vld),
        .pix_rdy    (pix_rdy),
        .row        (row),
        .col        (col),
        .out_vld_rc (out_vld_rc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .out_cnt    (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: every window pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_vld_rc) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse_unexp: got (%0d,%0d) want none",
                         row, col);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_pos", {16'd0, row, col}, {16'd0, mon_e});
            end
        end
    end

    task automatic push_rc(input int r, input int c);
        exp_q.push_back({8'(r), 8'(c)});
    endtask

    task automatic run_frame(input int w, input int h, input int s,
                             input bit tog, input bit mid,
                             input int stop_at, input int exp_cnt);
        int acc;
        int cyc;
        int idx;
        acc = 0;
        cyc = 0;
        @(posedge clk); #1;
        cfg_w = CW'(w);
        cfg_h = CW'(h);
        cfg_stride = 2'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rdy_rise", {31'd0, pix_rdy}, 1);
        while (acc < w * h && acc != stop_at && cyc < 2000) begin
            pix_vld = tog ? (cyc % 2 == 0) : 1'b1;
            if (mid && acc == 7) begin
                start = 1'b1;
                cfg_w = 8'd3;
                cfg_h = 8'd3;
                cfg_stride = 2'd3;
            end else begin
                start = 1'b0;
            end
            #3;
            if (pix_vld && pix_rdy) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        pix_vld = 1'b0;
        start = 1'b0;
        if (cyc >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got %0d want %0d", acc, w * h);
        end
        if (acc != stop_at) begin
            idx = 1;
            chk("rdy_fall", {31'd0, pix_rdy}, 0);
            chk("busy_flush", {31'd0, busy}, 1);
            while (!done && idx < 20) begin
                @(posedge clk); #1;
                idx++;
            end
            chk("done_lat", idx, FC + 1);
            chk("err_clr", {31'd0, err}, 0);
            chk("out_cnt", {16'd0, out_cnt}, exp_cnt);
            #4;
            chk("q_empty", exp_q.size(), 0);
            @(posedge clk); #1;
            chk("done_pulse", {31'd0, done}, 0);
            chk("cnt_hold", {16'd0, out_cnt}, exp_cnt);
        end
    endtask

    initial begin
        #2;
        chk("rst_rdy", {31'd0, pix_rdy}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_cnt", {16'd0, out_cnt}, 0);
        #10;
        rst_n = 1'b1;

        // 5x5 stride 1, continuous
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++) push_rc(r, c);
        run_frame(5, 5, 1, 1'b0, 1'b0, -1, 9);

        // 6x6 stride 2
        push_rc(2, 2);
        push_rc(2, 4);
        push_rc(4, 2);
        push_rc(4, 4);
        run_frame(6, 6, 2, 1'b0, 1'b0, -1, 4);

        // 5x5 stride 1, pix_vld toggling
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++) push_rc(r, c);
        run_frame(5, 5, 1, 1'b1, 1'b0, -1, 9);

        // illegal width
        @(posedge clk); #1;
        cfg_w = 8'd2;
        cfg_h = 8'd5;
        cfg_stride = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ill_done", {31'd0, done}, 1);
        chk("ill_err", {31'd0, err}, 1);
        chk("ill_rdy", {31'd0, pix_rdy}, 0);
        chk("ill_cnt", {16'd0, out_cnt}, 0);
        @(posedge clk); #1;
        chk("ill_done_off", {31'd0, done}, 0);
        chk("ill_err_hold", {31'd0, err}, 1);
        chk("ill_rdy2", {31'd0, pix_rdy}, 0);

        // start pulsed during RUN
        for (int r = 2; r <= 4; r++)
            for (int c = 2; c <= 4; c++) push_rc(r, c);
        run_frame(5, 5, 1, 1'b0, 1'b1, -1, 9);

        // reset mid-frame after 10 accepts
        run_frame(5, 5, 1, 1'b0, 1'b0, 10, 0);
        chk("pre_rst_row", {24'd0, row}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, pix_rdy}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_row", {24'd0, row}, 0);
        chk("mid_rst_col", {24'd0, col}, 0);
        chk("mid_rst_vld", {31'd0, out_vld_rc}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_err", {31'd0, err}, 0);
        chk("mid_rst_cnt", {16'd0, out_cnt}, 0);
        #10;
        rst_n = 1'b1;
        push_rc(2, 2);
        run_frame(3, 3, 1, 1'b0, 1'b0, -1, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
